axi_burst_master: RTL and testbench

Parametrised AXI4 master that moves whole cache lines as INCR bursts between the cache controller and the DDR interconnect. Writes are posted into an internal line queue and drained one burst at a time, with B responses checked. Reads fetch one line per request and return it as a single wide word. It supersedes the single-beat master: configurable width, burst length and queue depth, plus error reporting.

---
 rtl/axi_burst_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 cache-line master: posted write queue drained as INCR bursts, one-line reads.
// Optional macro AXI_RAW_ORDER_EN holds off reads that hit a queued or in-flight write line.
module axi_burst_master #(
   parameter  int ADDR_W   = 27,
   parameter  int DATA_W   = 128,
   parameter  int BEATS    = 4,
   parameter  int WQ_DEPTH = 4,
   parameter  int ID_W     = 4,
   localparam int LINE_W   = BEATS * DATA_W
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic                wr_req,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [LINE_W-1:0]   wr_data,
   output logic                wr_idle,
   output logic                wr_err,
   input  logic                rd_req,
   output logic                rd_ready,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic                rd_valid,
   output logic [LINE_W-1:0]   rd_data,
   output logic                rd_err,
   output logic [ID_W-1:0]     M_AXI_AWID,
   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [7:0]          M_AXI_AWLEN,
   output logic [2:0]          M_AXI_AWSIZE,
   output logic [1:0]          M_AXI_AWBURST,
   output logic                M_AXI_AWLOCK,
   output logic [3:0]          M_AXI_AWCACHE,
   output logic [2:0]          M_AXI_AWPROT,
   output logic [3:0]          M_AXI_AWQOS,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WLAST,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [ID_W-1:0]     M_AXI_BID,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY,
   output logic [ID_W-1:0]     M_AXI_ARID,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic [7:0]          M_AXI_ARLEN,
   output logic [2:0]          M_AXI_ARSIZE,
   output logic [1:0]          M_AXI_ARBURST,
   output logic                M_AXI_ARLOCK,
   output logic [3:0]          M_AXI_ARCACHE,
   output logic [2:0]          M_AXI_ARPROT,
   output logic [3:0]          M_AXI_ARQOS,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [ID_W-1:0]     M_AXI_RID,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RLAST,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY
);
   localparam int OFF = $clog2(LINE_W / 8);
   localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int AW  = $clog2(WQ_DEPTH);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

   wstate_t             wstate;
   rstate_t             rstate;
   logic [ADDR_W-1:0]   q_addr [WQ_DEPTH];
   logic [LINE_W-1:0]   q_line [WQ_DEPTH];
   logic [LINE_W-1:0]   w_line;
   logic [AW:0]         wptr, rptr;
   logic                full, empty, push, pop;
   logic [BW-1:0]       wbeat, wbeat_nxt, rbeat;
   logic                r_acc, r_err_nxt;
   logic                unused_in;

   function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
   endfunction

   assign M_AXI_AWID    = '0;
   assign M_AXI_AWLEN   = 8'(BEATS - 1);
   assign M_AXI_AWSIZE  = 3'($clog2(DATA_W / 8));
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0010;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWQOS   = 4'b0000;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARLEN   = 8'(BEATS - 1);
   assign M_AXI_ARSIZE  = 3'($clog2(DATA_W / 8));
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'b0010;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'b0000;

   assign unused_in = ^{M_AXI_BID, M_AXI_RID, wr_addr[OFF-1:0], rd_addr[OFF-1:0]};

   // Pointers carry one extra wrap bit: equal low bits plus differing MSB means full.
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty     = (wptr == rptr);
   assign wr_ready  = !full;
   assign push      = wr_req && !full;
   assign pop       = (wstate == W_IDLE) && !empty;
   assign wr_idle   = empty && (wstate == W_IDLE);
   assign wbeat_nxt = wbeat + 1'b1;
   assign r_err_nxt = r_acc | (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != (rbeat == LAST_BEAT));

   always_ff @(posedge ACLK) begin
      if (push) begin
         q_addr[wptr[AW-1:0]] <= align(wr_addr);
         q_line[wptr[AW-1:0]] <= wr_data;
      end
      if (pop)
         w_line <= q_line[rptr[AW-1:0]];
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)
         wptr <= '0;
      else if (push)
         wptr <= wptr + 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wstate        <= W_IDLE;
         rptr          <= '0;
         wbeat         <= '0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_WLAST   <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         wr_err        <= 1'b0;
      end else begin
         wr_err <= 1'b0;
         case (wstate)
            W_IDLE: if (pop) begin
               M_AXI_AWADDR  <= q_addr[rptr[AW-1:0]];
               M_AXI_AWVALID <= 1'b1;
               rptr          <= rptr + 1'b1;
               wstate        <= W_ADDR;
            end
            W_ADDR: if (M_AXI_AWREADY) begin
               M_AXI_AWVALID <= 1'b0;
               M_AXI_WVALID  <= 1'b1;
               M_AXI_WDATA   <= w_line[DATA_W-1:0];
               M_AXI_WLAST   <= (BEATS == 1);
               wbeat         <= '0;
               wstate        <= W_DATA;
            end
            W_DATA: if (M_AXI_WREADY) begin
               if (wbeat == LAST_BEAT) begin
                  M_AXI_WVALID <= 1'b0;
                  M_AXI_WLAST  <= 1'b0;
                  M_AXI_BREADY <= 1'b1;
                  wstate       <= W_RESP;
               end else begin
                  wbeat        <= wbeat_nxt;
                  M_AXI_WDATA  <= w_line[wbeat_nxt*DATA_W +: DATA_W];
                  M_AXI_WLAST  <= (wbeat_nxt == LAST_BEAT);
               end
            end
            W_RESP: if (M_AXI_BVALID) begin
               M_AXI_BREADY <= 1'b0;
               wr_err       <= (M_AXI_BRESP != 2'b00);
               wstate       <= W_IDLE;
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

`ifdef AXI_RAW_ORDER_EN
   logic        raw_hit;
   logic [AW:0] qcount;
   assign qcount = wptr - rptr;

   // A line is pending while it sits in a live queue slot or is the burst in progress.
   always_comb begin
      logic [AW-1:0] off;
      off     = '0;
      raw_hit = (wstate != W_IDLE) && (M_AXI_AWADDR == align(rd_addr));
      for (int i = 0; i < WQ_DEPTH; i++) begin
         off = AW'(i) - rptr[AW-1:0];
         if (({1'b0, off} < qcount) && (q_addr[i] == align(rd_addr)))
            raw_hit = 1'b1;
      end
   end

   assign rd_ready = (rstate == R_IDLE) && !raw_hit;
`else
   assign rd_ready = (rstate == R_IDLE);
`endif

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rstate        <= R_IDLE;
         rbeat         <= '0;
         r_acc         <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
         rd_valid      <= 1'b0;
         rd_err        <= 1'b0;
         rd_data       <= '0;
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         case (rstate)
            R_IDLE: if (rd_req && rd_ready) begin
               M_AXI_ARADDR  <= align(rd_addr);
               M_AXI_ARVALID <= 1'b1;
               rstate        <= R_ADDR;
            end
            R_ADDR: if (M_AXI_ARREADY) begin
               M_AXI_ARVALID <= 1'b0;
               M_AXI_RREADY  <= 1'b1;
               rbeat         <= '0;
               r_acc         <= 1'b0;
               rstate        <= R_DATA;
            end
            R_DATA: if (M_AXI_RVALID) begin
               rd_data[rbeat*DATA_W +: DATA_W] <= M_AXI_RDATA;
               // Completion follows the beat count; a misplaced RLAST only flags an error.
               if (rbeat == LAST_BEAT) begin
                  M_AXI_RREADY <= 1'b0;
                  rd_valid     <= 1'b1;
                  rd_err       <= r_err_nxt;
                  rstate       <= R_IDLE;
               end else begin
                  rbeat <= rbeat + 1'b1;
                  r_acc <= r_err_nxt;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master (DATA_W=128, BEATS=4, WQ_DEPTH=4); the slave side is driven by hand.
module tb_axi_burst_master;
   localparam int ADDR_W = 27;
   localparam int DATA_W = 128;
   localparam int LINE_W = 512;
   localparam int ID_W   = 4;

   logic                ACLK, ARESETN;
   logic                wr_req, wr_ready, wr_idle, wr_err;
   logic [ADDR_W-1:0]   wr_addr, rd_addr;
   logic [LINE_W-1:0]   wr_data, rd_data;
   logic                rd_req, rd_ready, rd_valid, rd_err;
   logic [ID_W-1:0]     awid, arid, bid, rid;
   logic [ADDR_W-1:0]   awaddr, araddr;
   logic [7:0]          awlen, arlen;
   logic [2:0]          awsize, arsize, awprot, arprot;
   logic [1:0]          awburst, arburst, bresp, rresp;
   logic                awlock, arlock, awvalid, awready, arvalid, arready;
   logic [3:0]          awcache, arcache, awqos, arqos;
   logic [DATA_W-1:0]   wdata, rdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast, wvalid, wready, bvalid, bready;
   logic                rlast, rvalid, rready;

   int n_cmp = 0;
   int n_bad = 0;

   axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(4), .WQ_DEPTH(4), .ID_W(ID_W)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_idle(wr_idle), .wr_err(wr_err),
      .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_err(rd_err),
      .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
      .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
      .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
      .M_AXI_WREADY(wready),
      .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
      .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] line4(input logic [7:0] b0, b1, b2, b3);
      return {{16{b3}}, {16{b2}}, {16{b1}}, {16{b0}}};
   endfunction

   task automatic push(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_req  = 1'b0;
   endtask

   // Acts as the write slave for one burst, from AWVALID through the B handshake.
   task automatic serve_write(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                              input logic [1:0] resp);
      int i;
      i = 0;
      while (awvalid !== 1'b1 && i < 40) begin
         tick();
         i++;
      end
      chk("aw_valid", awvalid, 1'b1);
      chk("aw_addr", awaddr, a);
      chk("aw_len", awlen, 8'd3);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      chk("aw_drop", awvalid, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("w_valid", wvalid, 1'b1);
         chk("w_data", wdata, line[k*DATA_W +: DATA_W]);
         chk("w_last", wlast, (k == 3));
         wready = 1'b1;
         tick();
         wready = 1'b0;
      end
      chk("w_done", wvalid, 1'b0);
      chk("b_ready", bready, 1'b1);
      bvalid = 1'b1;
      bresp  = resp;
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk("b_drop", bready, 1'b0);
      chk("wr_err", wr_err, (resp != 2'b00));
   endtask

   // Acts as the read slave from ARVALID to the rd_valid pulse.
   task automatic read_data(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line,
                            input int err_beat, input int last_beat, input logic exp_err);
      chk("ar_valid", arvalid, 1'b1);
      chk("ar_addr", araddr, a);
      chk("ar_len", arlen, 8'd3);
      chk("ar_size", arsize, 3'd4);
      chk("ar_burst", arburst, 2'b01);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("ar_drop", arvalid, 1'b0);
      chk("r_ready", rready, 1'b1);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         rvalid = 1'b1;
         rdata  = line[k*DATA_W +: DATA_W];
         rresp  = (k == err_beat) ? 2'b10 : 2'b00;
         rlast  = (k == last_beat);
         tick();
         rvalid = 1'b0;
         rlast  = 1'b0;
         rresp  = 2'b00;
         if (k < 3) chk("rd_early", rd_valid, 1'b0);
      end
      chk("rd_valid", rd_valid, 1'b1);
      chk("rd_data", rd_data, line);
      chk("rd_err", rd_err, exp_err);
      chk("r_drop", rready, 1'b0);
      chk("rd_ready_back", rd_ready, 1'b1);
      tick();
      chk("rd_valid_pulse", rd_valid, 1'b0);
      chk("rd_err_pulse", rd_err, 1'b0);
   endtask

   initial begin
      logic [LINE_W-1:0] la, lb, lc, ld, le, lf, lr;
      ARESETN = 1'b0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0;
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bid = '0; bresp = 2'b00; bvalid = 1'b0;
      rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b1);
      chk("rst_rd_ready", rd_ready, 1'b1);
      chk("rst_wr_idle", wr_idle, 1'b1);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_rd_err", rd_err, 1'b0);
      chk("rst_wr_err", wr_err, 1'b0);
      chk("rst_rd_data", rd_data, '0);
      chk("awcache", awcache, 4'b0010);
      chk("wstrb", wstrb, {(DATA_W/8){1'b1}});
      ARESETN = 1'b1;
      tick();

      // single write burst, unaligned address, latency check
      la = line4(8'h11, 8'h22, 8'h33, 8'h44);
      push(27'h0000_123, la);
      chk("wlat_aw_early", awvalid, 1'b0);
      chk("wlat_busy", wr_idle, 1'b0);
      tick();
      chk("wlat_aw", awvalid, 1'b1);
      serve_write(27'h0000_100, la, 2'b00);
      chk("wr_idle_after_b", wr_idle, 1'b1);

      // SLVERR on B gives one wr_err pulse
      lb = line4(8'h55, 8'h66, 8'h77, 8'h88);
      push(27'h0000_240, lb);
      serve_write(27'h0000_240, lb, 2'b10);
      tick();
      chk("wr_err_pulse", wr_err, 1'b0);

      // queue full: A held in W_ADDR, B..E fill the queue, F is dropped
      la = line4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      lb = line4(8'hB0, 8'hB1, 8'hB2, 8'hB3);
      lc = line4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
      ld = line4(8'hD0, 8'hD1, 8'hD2, 8'hD3);
      le = line4(8'hE0, 8'hE1, 8'hE2, 8'hE3);
      lf = line4(8'hF0, 8'hF1, 8'hF2, 8'hF3);
      push(27'h0001_000, la);
      tick();
      chk("qf_a_inflight", awvalid, 1'b1);
      chk("qf_rdy_b", wr_ready, 1'b1);
      push(27'h0001_040, lb);
      chk("qf_rdy_c", wr_ready, 1'b1);
      push(27'h0001_080, lc);
      chk("qf_rdy_d", wr_ready, 1'b1);
      push(27'h0001_0C0, ld);
      chk("qf_rdy_e", wr_ready, 1'b1);
      push(27'h0001_100, le);
      chk("qf_full", wr_ready, 1'b0);
      push(27'h0001_140, lf);
      chk("qf_still_full", wr_ready, 1'b0);
      serve_write(27'h0001_000, la, 2'b00);
      serve_write(27'h0001_040, lb, 2'b00);
      serve_write(27'h0001_080, lc, 2'b00);
      serve_write(27'h0001_0C0, ld, 2'b00);
      serve_write(27'h0001_100, le, 2'b00);
      chk("qf_drained", wr_idle, 1'b1);
      repeat (3) tick();
      chk("qf_no_sixth", awvalid, 1'b0);

      // read path, clean and with errors
      lr = line4(8'hA5, 8'hB6, 8'hC7, 8'hD8);
      chk("rd_ready_idle", rd_ready, 1'b1);
      rd_req = 1'b1; rd_addr = 27'h0000_200;
      tick();
      rd_req = 1'b0;
      read_data(27'h0000_200, lr, -1, 3, 1'b0);

      lr = line4(8'h01, 8'h02, 8'h03, 8'h04);
      rd_req = 1'b1; rd_addr = 27'h0000_23F;
      tick();
      rd_req = 1'b0;
      read_data(27'h0000_200, lr, 2, 3, 1'b1);

      lr = line4(8'h71, 8'h72, 8'h73, 8'h74);
      rd_req = 1'b1; rd_addr = 27'h0000_300;
      tick();
      rd_req = 1'b0;
      read_data(27'h0000_300, lr, -1, 1, 1'b1);

      // reset during W_DATA beat 2 with one more line queued behind it
      la = line4(8'h81, 8'h82, 8'h83, 8'h84);
      lb = line4(8'h91, 8'h92, 8'h93, 8'h94);
      push(27'h0000_080, la);
      tick();
      awready = 1'b1;
      tick();
      awready = 1'b0;
      wready = 1'b1; wr_req = 1'b1; wr_addr = 27'h0000_0C0; wr_data = lb;
      tick();
      wr_req = 1'b0;
      tick();
      wready = 1'b0;
      chk("mid_beat2", wdata, la[2*DATA_W +: DATA_W]);
      chk("mid_busy", wr_idle, 1'b0);
      ARESETN = 1'b0;
      #1;
      chk("arst_awvalid", awvalid, 1'b0);
      chk("arst_wvalid", wvalid, 1'b0);
      chk("arst_bready", bready, 1'b0);
      chk("arst_wdata", wdata, '0);
      chk("arst_wr_idle", wr_idle, 1'b1);
      chk("arst_wr_ready", wr_ready, 1'b1);
      #2;
      ARESETN = 1'b1;
      tick();
      tick();
      chk("arst_queue_empty", awvalid, 1'b0);
      lc = line4(8'hC9, 8'hCA, 8'hCB, 8'hCC);
      push(27'h0000_1C0, lc);
      serve_write(27'h0000_1C0, lc, 2'b00);
      chk("arst_recover_idle", wr_idle, 1'b1);

      // read of a line with a write still outstanding
      la = line4(8'h4A, 8'h4B, 8'h4C, 8'h4D);
      lr = line4(8'h5A, 8'h5B, 8'h5C, 8'h5D);
      push(27'h0000_400, la);
      rd_req = 1'b1; rd_addr = 27'h0000_400;
`ifdef AXI_RAW_ORDER_EN
      chk("raw_block_queued", rd_ready, 1'b0);
      tick();
      chk("raw_block_inflight", rd_ready, 1'b0);
      tick();
      chk("raw_no_ar", arvalid, 1'b0);
      serve_write(27'h0000_400, la, 2'b00);
      chk("raw_release", rd_ready, 1'b1);
      tick();
      rd_req = 1'b0;
      read_data(27'h0000_400, lr, -1, 3, 1'b0);
`else
      chk("raw_free", rd_ready, 1'b1);
      tick();
      rd_req = 1'b0;
      read_data(27'h0000_400, lr, -1, 3, 1'b0);
      serve_write(27'h0000_400, la, 2'b00);
`endif
      chk("final_idle", wr_idle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
